// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scroll encoder.
//
// Display code layout (8 bits per digit):
//   bit 7    : blank (digit dark)
//   bit 6    : decimal point
//   bit 5    : dash
//   bits 4:0 : glyph index 0..22
//
// Contents: code constants, glyph indices, the encoder state enum and a
// helper that turns a glyph index into a full display code.
package sevenseg_pkg;

  localparam logic [7:0] CODE_BLANK = 8'h80;
  localparam logic [7:0] CODE_DP    = 8'h40;
  localparam logic [7:0] CODE_DASH  = 8'h20;

  localparam logic [4:0] GLYPH_H    = 5'd16;
  localparam logic [4:0] GLYPH_APOS = 5'd17;
  localparam logic [4:0] GLYPH_R    = 5'd18;
  localparam logic [4:0] GLYPH_T_LC = 5'd19;
  localparam logic [4:0] GLYPH_R_LC = 5'd20;
  localparam logic [4:0] GLYPH_S    = 5'd21;
  localparam logic [4:0] GLYPH_T    = 5'd22;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DRAIN  = 2'd2,
    SCROLL = 2'd3
  } state_e;

  function automatic logic [7:0] glyph_code(input logic [4:0] idx);
    return {3'b000, idx};
  endfunction

endpackage

// File: rtl/ascii_to_sevenseg_code.sv
// Combinational ASCII to seven-segment display code mapper.
//
// Ports:
//   ascii  in   8  ASCII character
//   code   out  8  display code (glyph, dash or blank)
//   is_dp  out  1  character is '.', which decorates the previous entry
//                  rather than occupying a digit of its own; code is then
//                  8'hC0 for the case where there is no previous entry
module ascii_to_sevenseg_code
  import sevenseg_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [7:0] code,
  output logic       is_dp
);

  always_comb begin
    code  = CODE_DASH;
    is_dp = 1'b0;
    unique case (ascii)
      8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
      8'h35, 8'h36, 8'h37, 8'h38, 8'h39: code = {4'h0, ascii[3:0]};
      8'h41, 8'h61: code = glyph_code(5'd10);
      8'h42, 8'h62: code = glyph_code(5'd11);
      8'h43, 8'h63: code = glyph_code(5'd12);
      8'h44, 8'h64: code = glyph_code(5'd13);
      8'h45, 8'h65: code = glyph_code(5'd14);
      8'h46, 8'h66: code = glyph_code(5'd15);
      8'h48, 8'h68: code = glyph_code(GLYPH_H);
      8'h27:        code = glyph_code(GLYPH_APOS);
      8'h52:        code = glyph_code(GLYPH_R);
      8'h74:        code = glyph_code(GLYPH_T_LC);
      8'h72:        code = glyph_code(GLYPH_R_LC);
      8'h53, 8'h73: code = glyph_code(GLYPH_S);
      8'h54:        code = glyph_code(GLYPH_T);
      8'h2D:        code = CODE_DASH;
      8'h20:        code = CODE_BLANK;
      8'h2E: begin
        code  = CODE_BLANK | CODE_DP;
        is_dp = 1'b1;
      end
      default:      code = CODE_DASH;
    endcase
  end

endmodule

// File: rtl/sevenseg_scroll_enc.sv
// Seven-segment message scroller: buffers an ASCII message received over a
// valid/ready byte stream and scrolls it right-to-left across NDIGITS digits.
//
// Ports:
//   clk       in   1          system clock
//   rst       in   1          synchronous active-high reset
//   in_valid  in   1          input character valid
//   in_ready  out  1          character accepted this cycle if in_valid
//   in_data   in   8          ASCII character
//   in_last   in   1          final character of the message
//   busy      out  1          not idle
//   overflow  out  1          pulse: first character of a message dropped
//   done      out  1          pulse: scroll pass finished, back to idle
//   codes     out  8*NDIGITS  display codes, leftmost digit in the MSBs
//
// Optional feature macro: SEVENSEG_SCROLL_LOOP_EN -- repeat the scroll pass
// while no new character is waiting at the end of a pass.
module sevenseg_scroll_enc
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS      = 8,
  parameter int MSG_DEPTH    = 16,
  parameter int SCROLL_TICKS = 25_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   busy,
  output logic                   overflow,
  output logic                   done,
  output logic [8*NDIGITS-1:0]   codes
);

  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam int PW = $clog2(MSG_DEPTH + NDIGITS + 1);
  localparam int TW = $clog2(SCROLL_TICKS);

  state_e                 state_q, state_d;
  logic   [LW-1:0]        wptr_q, wptr_d;
  logic   [LW-1:0]        len_q, len_d;
  logic   [PW-1:0]        pos_q, pos_d;
  logic   [TW-1:0]        tick_q, tick_d;
  logic                   first_drop_q, first_drop_d;
  logic                   overflow_q, overflow_d;
  logic                   done_q, done_d;
  logic   [8*NDIGITS-1:0] codes_q, codes_d;
  logic   [7:0]           msg_q [MSG_DEPTH];

  logic                   wr_en;
  logic   [AW-1:0]        wr_addr;
  logic   [7:0]           wr_data;

  logic   [7:0]           char_code;
  logic                   char_is_dp;
  logic                   accept;
  logic   [LW-1:0]        prev_idx;
  logic   [PW-1:0]        end_pos;
  logic   [8*NDIGITS-1:0] window;

  ascii_to_sevenseg_code u_map (
    .ascii (in_data),
    .code  (char_code),
    .is_dp (char_is_dp)
  );

  assign in_ready = (state_q != SCROLL);
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid && in_ready;
  assign prev_idx = wptr_q - LW'(1);
  assign end_pos  = PW'(len_q) + PW'(NDIGITS);
  assign overflow = overflow_q;
  assign done     = done_q;
  assign codes    = codes_q;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    len_d        = len_q;
    pos_d        = pos_q;
    tick_d       = tick_q;
    first_drop_d = first_drop_q;
    overflow_d   = 1'b0;
    done_d       = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = wptr_q[AW-1:0];
    wr_data      = char_code;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // A leading '.' has nothing to decorate; the mapper's 8'hC0 is stored.
          wr_en   = 1'b1;
          wr_addr = '0;
          wptr_d  = LW'(1);
          if (in_last) begin
            state_d = SCROLL;
            len_d   = LW'(1);
            pos_d   = PW'(1);
            tick_d  = '0;
          end else begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (char_is_dp) begin
            // '.' folds into the previous entry and takes no slot.
            wr_addr = prev_idx[AW-1:0];
            wr_data = msg_q[prev_idx[AW-1:0]] | CODE_DP;
            if (in_last) begin
              state_d = SCROLL;
              len_d   = wptr_q;
              pos_d   = PW'(1);
              tick_d  = '0;
            end
          end else begin
            wptr_d = wptr_q + LW'(1);
            if (in_last) begin
              state_d = SCROLL;
              len_d   = wptr_q + LW'(1);
              pos_d   = PW'(1);
              tick_d  = '0;
            end else if (wptr_q == LW'(MSG_DEPTH - 1)) begin
              state_d      = DRAIN;
              len_d        = LW'(MSG_DEPTH);
              first_drop_d = 1'b1;
            end
          end
        end
      end

      DRAIN: begin
        if (accept) begin
          overflow_d   = first_drop_q;
          first_drop_d = 1'b0;
          if (in_last) begin
            state_d = SCROLL;
            pos_d   = PW'(1);
            tick_d  = '0;
          end
        end
      end

      SCROLL: begin
        if (tick_q == TW'(SCROLL_TICKS - 1)) begin
          tick_d = '0;
          if (pos_q == end_pos) begin
`ifdef SEVENSEG_SCROLL_LOOP_EN
            if (!in_valid) begin
              pos_d = PW'(1);
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Digit k (0 = leftmost) shows entry pos-NDIGITS+k when it lies in the message.
  always_comb begin
    int idx;
    window = {NDIGITS{CODE_BLANK}};
    for (int k = 0; k < NDIGITS; k++) begin
      idx = int'(pos_q) - NDIGITS + k;
      if (idx >= 0 && idx < int'(len_q)) begin
        window[8*(NDIGITS-1-k) +: 8] = msg_q[idx[AW-1:0]];
      end
    end
  end

  assign codes_d = (state_q == SCROLL) ? window : {NDIGITS{CODE_BLANK}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      len_q        <= '0;
      pos_q        <= '0;
      tick_q       <= '0;
      first_drop_q <= 1'b0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      codes_q      <= {NDIGITS{CODE_BLANK}};
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      len_q        <= len_d;
      pos_q        <= pos_d;
      tick_q       <= tick_d;
      first_drop_q <= first_drop_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
      codes_q      <= codes_d;
    end
  end

  // Message storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      msg_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_sevenseg_scroll_enc.sv
// Directed self-checking bench for sevenseg_scroll_enc with NDIGITS=4,
// MSG_DEPTH=8, SCROLL_TICKS=4. Inputs change and outputs are sampled 1 time
// unit after the rising edge.
module tb_sevenseg_scroll_enc;

  localparam int ND = 4;
  localparam int MD = 8;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          busy;
  logic          overflow;
  logic          done;
  logic [8*ND-1:0] codes;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sevenseg_scroll_enc #(
    .NDIGITS      (ND),
    .MSG_DEPTH    (MD),
    .SCROLL_TICKS (ST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .busy     (busy),
    .overflow (overflow),
    .done     (done),
    .codes    (codes)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] c, input logic last);
    in_valid = 1'b1;
    in_data  = c;
    in_last  = last;
    cyc(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc(1);
      if (done === 1'b1) seen = 1'b1;
    end
    check(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic watch_no_done(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (done !== 1'b0) seen = 1'b1;
    end
    check(tag, {31'b0, seen}, 32'd0);
  endtask

  logic [31:0] tr_steps [6];

  initial begin
    tr_steps[0] = 32'h80808013;
    tr_steps[1] = 32'h80801314;
    tr_steps[2] = 32'h80131480;
    tr_steps[3] = 32'h13148080;
    tr_steps[4] = 32'h14808080;
    tr_steps[5] = 32'h80808080;

    // Reset state
    cyc(2);
    rst = 1'b0;
    check("rst_codes", codes, 32'h80808080);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);

    // "tr": full pass, step by step
    send("t", 1'b0);
    check("tr_fill_busy", {31'b0, busy}, 32'd1);
    check("tr_fill_ready", {31'b0, in_ready}, 32'd1);
    send("r", 1'b1);
    check("tr_scroll_ready", {31'b0, in_ready}, 32'd0);
    check("tr_first_cycle_blank", codes, 32'h80808080);
    cyc(1);
    check("tr_step1", codes, tr_steps[0]);
    for (int i = 1; i < 6; i++) begin
      cyc(ST);
      check($sformatf("tr_step%0d", i + 1), codes, tr_steps[i]);
    end
    cyc(2);
    check("tr_last_step_hold", {30'b0, busy, done}, 32'd2);
    cyc(1);
    check("tr_done", {29'b0, done, busy, in_ready}, 32'b101);
    cyc(1);
    check("tr_done_pulse", {31'b0, done}, 32'd0);

    // "E.rr": decimal point folds into the previous entry
    send("E", 1'b0);
    send(".", 1'b0);
    send("r", 1'b0);
    send("r", 1'b1);
    cyc(1);
    check("edp_p1", codes, 32'h8080804E);
    cyc(12);
    check("edp_p4", codes, 32'h4E141480);
    wait_done(20, "edp_done");

    // Mapping: 'H' glyph, unknown byte as dash
    send("H", 1'b0);
    send("x", 1'b1);
    cyc(1);
    check("hx_p1", codes, 32'h80808010);
    cyc(ST);
    check("hx_p2", codes, 32'h80801020);
    wait_done(30, "hx_done");

    // Overflow: 10 characters into an 8-entry buffer
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 1'b0);
    check("ovf_before", {30'b0, busy, overflow}, 32'd2);
    check("ovf_ready7", {31'b0, in_ready}, 32'd1);
    send("8", 1'b0);
    check("ovf_pulse", {31'b0, overflow}, 32'd1);
    check("ovf_ready8", {31'b0, in_ready}, 32'd1);
    send("9", 1'b1);
    check("ovf_once", {31'b0, overflow}, 32'd0);
    cyc(1);
    check("ovf_p1", codes, 32'h80808000);
    cyc(28);
    check("ovf_p8", codes, 32'h04050607);
    wait_done(30, "ovf_done");

    // in_valid held during SCROLL is not accepted until IDLE
    send("A", 1'b1);
    in_valid = 1'b1;
    in_data  = "5";
    in_last  = 1'b1;
    check("hold_ready", {31'b0, in_ready}, 32'd0);
    cyc(1);
    check("hold_no_write", codes, 32'h8080800A);
    wait_done(30, "hold_done");
    check("hold_idle", {30'b0, in_ready, busy}, 32'd2);
    cyc(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("hold_accepted", {31'b0, busy}, 32'd1);
    cyc(1);
    check("hold_p1", codes, 32'h80808005);
    wait_done(30, "hold_done2");

    // Reset at p=3
    send("t", 1'b0);
    send("r", 1'b1);
    cyc(9);
    check("rst_mid_p3", codes, 32'h80131480);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_mid_codes", codes, 32'h80808080);
    check("rst_mid_state", {29'b0, busy, in_ready, done}, 32'b010);
    watch_no_done(30, "rst_mid_no_done");
    send("A", 1'b1);
    cyc(1);
    check("rst_mid_restart", codes, 32'h8080800A);
    wait_done(30, "rst_mid_done");

`ifdef SEVENSEG_SCROLL_LOOP_EN
    // Looping pass while no input is pending
    send("A", 1'b1);
    cyc(1);
    check("loop_p1", codes, 32'h8080800A);
    watch_no_done(20, "loop_no_done");
    check("loop_reenter", codes, 32'h8080800A);
    check("loop_busy", {31'b0, busy}, 32'd1);
    in_valid = 1'b1;
    in_data  = "B";
    in_last  = 1'b1;
    wait_done(30, "loop_exit_done");
    cyc(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("loop_next_msg", {31'b0, busy}, 32'd1);
    wait_done(30, "loop_next_done");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
